// File: rtl/rpn_sequenciador_pilha.sv
// rtl/rpn_sequenciador_pilha.sv - RPN sequencer with a DEPTH-entry LIFO operand stack feeding an external ALU.
// Optional macro SEQ_RPN_DUP_EN adds the dup_pulso input (duplicate top of stack).
module rpn_sequenciador_pilha #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OPW   = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] entrada_dados,
    input  logic [OPW-1:0]   op_codigo,
    input  logic             push_pulso,
    input  logic             op_pulso,
`ifdef SEQ_RPN_DUP_EN
    input  logic             dup_pulso,
`endif
    input  logic             limpar_pulso,
    input  logic [WIDTH-1:0] alu_resultado,
    input  logic             alu_valido,
    output logic [WIDTH-1:0] operando_A,
    output logic [WIDTH-1:0] operando_B,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_inicio,
    output logic             enable_reg_A,
    output logic             enable_reg_B,
    output logic             enable_reg_Resultado,
    output logic [WIDTH-1:0] topo,
    output logic [CW-1:0]    profundidade,
    output logic             ocupado,
    output logic             erro_overflow,
    output logic             erro_underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {ST_IDLE, ST_EXEC} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [CW-1:0]    r_sp;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [OPW-1:0]   r_alu_op;
    logic             r_inicio;
    logic             r_en_a;
    logic             r_en_b;
    logic             r_en_res;
    logic             r_ovf;
    logic             r_unf;

    logic [AW-1:0]    w_idx_new;
    logic [AW-1:0]    w_idx_top;
    logic [AW-1:0]    w_idx_sec;
    logic             w_full;
    logic             w_empty;
    logic             w_has_two;
    logic             w_dup;
    logic             w_do_push;
    logic             w_do_dup;
    logic             w_do_op;
    logic             w_do_wb;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_clear;

`ifdef SEQ_RPN_DUP_EN
    assign w_dup = dup_pulso;
`else
    assign w_dup = 1'b0;
`endif

    // Indices are only used when sp guarantees they are in range.
    assign w_idx_new = AW'(r_sp);
    assign w_idx_top = AW'(r_sp - CW'(1));
    assign w_idx_sec = AW'(r_sp - CW'(2));
    assign w_full    = (r_sp == CW'(DEPTH));
    assign w_empty   = (r_sp == '0);
    assign w_has_two = (r_sp >= CW'(2));

    always_comb begin
        w_state_next = r_state;
        w_do_push    = 1'b0;
        w_do_dup     = 1'b0;
        w_do_op      = 1'b0;
        w_do_wb      = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        w_clear      = 1'b0;
        if (limpar_pulso) begin
            w_clear      = 1'b1;
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_pulso) begin
                        if (w_has_two) begin
                            w_do_op      = 1'b1;
                            w_state_next = ST_EXEC;
                        end else begin
                            w_set_unf = 1'b1;
                        end
                    end else if (w_dup) begin
                        if (w_full)       w_set_ovf = 1'b1;
                        else if (w_empty) w_set_unf = 1'b1;
                        else              w_do_dup  = 1'b1;
                    end else if (push_pulso) begin
                        if (w_full) w_set_ovf = 1'b1;
                        else        w_do_push = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (alu_valido) begin
                        w_do_wb      = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_sp     <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_alu_op <= '0;
            r_inicio <= 1'b0;
            r_en_a   <= 1'b0;
            r_en_b   <= 1'b0;
            r_en_res <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
        end else begin
            r_state  <= w_state_next;
            r_inicio <= w_do_op;
            r_en_a   <= w_do_op;
            r_en_b   <= w_do_op;
            r_en_res <= w_do_wb;
            if (w_clear) begin
                r_sp  <= '0;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (w_set_ovf) r_ovf <= 1'b1;
                if (w_set_unf) r_unf <= 1'b1;
                if (w_do_push) begin
                    r_stack[w_idx_new] <= entrada_dados;
                    r_sp               <= r_sp + CW'(1);
                end
                if (w_do_dup) begin
                    r_stack[w_idx_new] <= r_stack[w_idx_top];
                    r_sp               <= r_sp + CW'(1);
                end
                if (w_do_op) begin
                    r_op_a   <= r_stack[w_idx_sec];
                    r_op_b   <= r_stack[w_idx_top];
                    r_alu_op <= op_codigo;
                end
                // Result replaces the older operand; the top slot becomes free.
                if (w_do_wb) begin
                    r_stack[w_idx_sec] <= alu_resultado;
                    r_sp               <= r_sp - CW'(1);
                end
            end
        end
    end

    assign operando_A           = r_op_a;
    assign operando_B           = r_op_b;
    assign alu_op               = r_alu_op;
    assign alu_inicio           = r_inicio;
    assign enable_reg_A         = r_en_a;
    assign enable_reg_B         = r_en_b;
    assign enable_reg_Resultado = r_en_res;
    assign topo                 = w_empty ? '0 : r_stack[w_idx_top];
    assign profundidade         = r_sp;
    assign ocupado              = (r_state == ST_EXEC);
    assign erro_overflow        = r_ovf;
    assign erro_underflow       = r_unf;

endmodule

// File: tb/tb_rpn_sequenciador_pilha.sv
// tb/tb_rpn_sequenciador_pilha.sv - scoreboard bench for rpn_sequenciador_pilha.
module tb_rpn_sequenciador_pilha;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int OW  = 3;
    localparam int CWL = $clog2(D + 1);

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   entrada_dados;
    logic [OW-1:0]  op_codigo;
    logic           push_pulso;
    logic           op_pulso;
`ifdef SEQ_RPN_DUP_EN
    logic           dup_pulso;
`endif
    logic           limpar_pulso;
    logic [W-1:0]   alu_resultado;
    logic           alu_valido;
    logic [W-1:0]   operando_A;
    logic [W-1:0]   operando_B;
    logic [OW-1:0]  alu_op;
    logic           alu_inicio;
    logic           enable_reg_A;
    logic           enable_reg_B;
    logic           enable_reg_Resultado;
    logic [W-1:0]   topo;
    logic [CWL-1:0] profundidade;
    logic           ocupado;
    logic           erro_overflow;
    logic           erro_underflow;

    rpn_sequenciador_pilha #(.WIDTH(W), .DEPTH(D), .OPW(OW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .entrada_dados        (entrada_dados),
        .op_codigo            (op_codigo),
        .push_pulso           (push_pulso),
        .op_pulso             (op_pulso),
`ifdef SEQ_RPN_DUP_EN
        .dup_pulso            (dup_pulso),
`endif
        .limpar_pulso         (limpar_pulso),
        .alu_resultado        (alu_resultado),
        .alu_valido           (alu_valido),
        .operando_A           (operando_A),
        .operando_B           (operando_B),
        .alu_op               (alu_op),
        .alu_inicio           (alu_inicio),
        .enable_reg_A         (enable_reg_A),
        .enable_reg_B         (enable_reg_B),
        .enable_reg_Resultado (enable_reg_Resultado),
        .topo                 (topo),
        .profundidade         (profundidade),
        .ocupado              (ocupado),
        .erro_overflow        (erro_overflow),
        .erro_underflow       (erro_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [OW-1:0] op;
    } op_t;

    op_t          exp_ops[$];
    logic [W-1:0] exp_res[$];
    op_t          mon_e;
    logic [W-1:0] mon_r;
    logic [W-1:0] m_stack [D];
    int           m_sp;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [OW-1:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Output monitor: pops expectations whenever the DUT strobes.
    always @(negedge clk) begin
        if (!reset) begin
            if (alu_inicio) begin
                if (exp_ops.size() == 0) begin
                    check_val("spurious_inicio", 32'(alu_inicio), 32'd0);
                end else begin
                    mon_e = exp_ops.pop_front();
                    check_val("operando_A", 32'(operando_A), 32'(mon_e.a));
                    check_val("operando_B", 32'(operando_B), 32'(mon_e.b));
                    check_val("alu_op", 32'(alu_op), 32'(mon_e.op));
                    check_val("en_ab", 32'({enable_reg_A, enable_reg_B}), 32'd3);
                end
            end
            if (enable_reg_Resultado) begin
                if (exp_res.size() == 0) begin
                    check_val("spurious_wb", 32'(enable_reg_Resultado), 32'd0);
                end else begin
                    mon_r = exp_res.pop_front();
                    check_val("wb_topo", 32'(topo), 32'(mon_r));
                end
            end
        end
    end

    task automatic push(input logic [W-1:0] v);
        entrada_dados = v;
        push_pulso    = 1'b1;
        @(negedge clk);
        push_pulso    = 1'b0;
        if (m_sp < D) begin
            m_stack[m_sp] = v;
            m_sp++;
        end
    endtask

    task automatic op_issue(input logic [OW-1:0] op, input bit expect_wb);
        logic [W-1:0] r;
        op_codigo = op;
        op_pulso  = 1'b1;
        if (m_sp >= 2) begin
            exp_ops.push_back({m_stack[m_sp-2], m_stack[m_sp-1], op});
            r = alu_fn(m_stack[m_sp-2], m_stack[m_sp-1], op);
            if (expect_wb) begin
                exp_res.push_back(r);
                m_stack[m_sp-2] = r;
                m_sp--;
            end
        end
        @(negedge clk);
        op_pulso = 1'b0;
    endtask

    task automatic alu_respond(input int lat);
        bit seen = 0;
        repeat (lat) @(negedge clk);
        alu_resultado = alu_fn(operando_A, operando_B, alu_op);
        alu_valido    = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (enable_reg_Resultado) seen = 1;
        end
        alu_valido = 1'b0;
        check_val("wb_seen", 32'(seen), 32'd1);
    endtask

    task automatic limpar();
        limpar_pulso = 1'b1;
        @(negedge clk);
        limpar_pulso = 1'b0;
        m_sp = 0;
    endtask

    task automatic check_stack(input string tag);
        check_val({tag, "_depth"}, 32'(profundidade), 32'(m_sp));
        check_val({tag, "_topo"}, 32'(topo), 32'((m_sp > 0) ? m_stack[m_sp-1] : 8'h00));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; entrada_dados = '0; op_codigo = '0; push_pulso = 1'b0; op_pulso = 1'b0;
        limpar_pulso = 1'b0; alu_resultado = '0; alu_valido = 1'b0; m_sp = 0;
`ifdef SEQ_RPN_DUP_EN
        dup_pulso = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_stack("reset");
        check_val("reset_outs", 32'({operando_A, operando_B, alu_op, alu_inicio, ocupado,
                                      enable_reg_Resultado, erro_overflow, erro_underflow}), 32'd0);
        reset = 1'b0;

        // Basic add with 3-cycle ALU latency
        push(8'h05); push(8'h03);
        check_stack("t1_pre");
        op_issue(3'd0, 1);
        check_val("t1_ocupado", 32'(ocupado), 32'd1);
        alu_respond(3);
        check_stack("t1_post");
        check_val("t1_idle", 32'(ocupado), 32'd0);

        // Operand order with a 3-deep stack, minimum latency
        push(8'h40); push(8'h10);
        op_issue(3'd1, 1);
        alu_respond(0);
        check_stack("t1b");
        op_issue(3'd4, 1);
        alu_respond(1);
        check_stack("t1c");

        // Overflow then clear
        limpar();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        check_stack("t2_full");
        check_val("t2_ovf", 32'(erro_overflow), 32'd1);
        limpar();
        check_stack("t2_clr");
        check_val("t2_ovf_clr", 32'(erro_overflow), 32'd0);

        // Underflow
        push(8'h07);
        op_issue(3'd0, 1);
        check_val("t3_unf", 32'(erro_underflow), 32'd1);
        check_val("t3_inicio", 32'(alu_inicio), 32'd0);
        check_val("t3_ocupado", 32'(ocupado), 32'd0);
        check_stack("t3");

        // Push/op ignored during EXEC
        limpar();
        push(8'h0C); push(8'h0A);
        op_issue(3'd2, 1);
        entrada_dados = 8'h99; push_pulso = 1'b1; op_pulso = 1'b1;
        @(negedge clk);
        push_pulso = 1'b0; op_pulso = 1'b0;
        check_val("t4_depth", 32'(profundidade), 32'(m_sp + 1));
        check_val("t4_err", 32'({erro_overflow, erro_underflow}), 32'd0);
        check_val("t4_ocupado", 32'(ocupado), 32'd1);
        alu_respond(1);
        check_stack("t4_post");

        // Clear mid-EXEC discards the later result
        limpar();
        push(8'hFF); push(8'h01);
        op_issue(3'd0, 0);
        limpar();
        check_stack("t5_clr");
        alu_resultado = 8'h00; alu_valido = 1'b1;
        repeat (3) @(negedge clk);
        alu_valido = 1'b0;
        check_val("t5_no_wb", 32'(enable_reg_Resultado), 32'd0);
        check_stack("t5_post");

`ifdef SEQ_RPN_DUP_EN
        push(8'h0A);
        dup_pulso = 1'b1; @(negedge clk); dup_pulso = 1'b0;
        m_stack[m_sp] = m_stack[m_sp-1]; m_sp++;
        check_stack("t6_dup");
        op_issue(3'd0, 1);
        alu_respond(0);
        push(8'h01); push(8'h02); push(8'h03);
        dup_pulso = 1'b1; @(negedge clk); dup_pulso = 1'b0;
        check_val("t6_ovf", 32'(erro_overflow), 32'd1);
        check_stack("t6_full");
        limpar();
`endif

        check_val("ops_drained", 32'(exp_ops.size()), 32'd0);
        check_val("res_drained", 32'(exp_res.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
